// File: rtl/sifive_outstanding_tracker.sv
// Per-channel outstanding-transaction tracker with ready gating at MAX_OUT.
// Optional high-water mark output peak_o when SIFIVE_TRACKER_PEAK_EN is defined.
module sifive_outstanding_tracker #(
  parameter int N_CH    = 8,
  parameter int CNT_W   = 5,
  parameter int MAX_OUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req_valid,
  output logic [N_CH-1:0]       req_ready,
  input  logic [N_CH-1:0]       resp_valid,
  output logic [N_CH*CNT_W-1:0] cnt_o,
  output logic [N_CH-1:0]       req_fire_o,
  output logic [N_CH-1:0]       resp_fire_o,
  output logic                  err_o,
`ifdef SIFIVE_TRACKER_PEAK_EN
  output logic                  idle_o,
  output logic [N_CH*CNT_W-1:0] peak_o
`else
  output logic                  idle_o
`endif
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] OVF_C = CNT_W'(2**(CNT_W-1));

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  unf;
  logic [N_CH-1:0]  ovf;
  logic             err_q;

  // Handshake strobes: ready depends only on the registered count
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      req_ready[i] = ~reset & (cnt_q[i] < MAX_C);
    end
    req_fire_o  = req_valid & req_ready;
    resp_fire_o = resp_valid & {N_CH{~reset}};
  end

  // Next count per channel plus underflow/overflow detection
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      unf[i]   = 1'b0;
      ovf[i]   = 1'b0;
      if (cnt_q[i] >= OVF_C) begin
        ovf[i] = 1'b1;
      end else if (req_fire_o[i] && !resp_fire_o[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (resp_fire_o[i] && !req_fire_o[i]) begin
        if (cnt_q[i] == '0) unf[i] = 1'b1;
        else cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Count and sticky error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_q | (|unf) | (|ovf);
    end
  end

  // Flatten counts and derive idle from registered state only
  always_comb begin
    idle_o = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
      if (cnt_q[i] != '0) idle_o = 1'b0;
    end
  end

  assign err_o = err_q;

`ifdef SIFIVE_TRACKER_PEAK_EN
  logic [CNT_W-1:0] peak_q [N_CH];

  // High-water mark, saturating at MAX_OUT
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) peak_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_d[i] > peak_q[i])
          peak_q[i] <= (cnt_d[i] > MAX_C) ? MAX_C : cnt_d[i];
      end
    end
  end

  // Flatten peak values
  always_comb begin
    for (int i = 0; i < N_CH; i++) peak_o[i*CNT_W +: CNT_W] = peak_q[i];
  end
`endif

endmodule

// File: tb/tb_sifive_outstanding_tracker.sv
// Bench for sifive_outstanding_tracker: directed scenarios plus random
// traffic checked against an integer reference model.
module tb_sifive_outstanding_tracker;

  localparam int N = 8;
  localparam int W = 5;
  localparam int MAXO = 15;

  logic           clock = 0;
  logic           reset = 1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid = '0;
  logic [N*W-1:0] cnt_o;
  logic [N-1:0]   req_fire_o;
  logic [N-1:0]   resp_fire_o;
  logic           err_o;
  logic           idle_o;
`ifdef SIFIVE_TRACKER_PEAK_EN
  logic [N*W-1:0] peak_o;
`endif

  sifive_outstanding_tracker #(
    .N_CH(N), .CNT_W(W), .MAX_OUT(MAXO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .cnt_o(cnt_o),
    .req_fire_o(req_fire_o),
    .resp_fire_o(resp_fire_o),
    .err_o(err_o),
`ifdef SIFIVE_TRACKER_PEAK_EN
    .idle_o(idle_o),
    .peak_o(peak_o)
`else
    .idle_o(idle_o)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int  m_cnt [N];
  int  m_peak [N];
  bit  m_err;
  bit  known = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model
  task automatic step(input bit rst, input logic [N-1:0] rv,
                      input logic [N-1:0] sv);
    logic [N-1:0] rdy, rf, sf;
    bit idl;
    @(negedge clock);
    reset = rst;
    req_valid = rv;
    resp_valid = sv;
    #1;
    idl = 1;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !rst && m_cnt[i] < MAXO;
      if (m_cnt[i] != 0) idl = 0;
    end
    rf = rv & rdy;
    sf = rst ? '0 : sv;
    check("req_ready", req_ready, rdy);
    check("req_fire", req_fire_o, rf);
    check("resp_fire", resp_fire_o, sf);
    if (known) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cnt%0d", i), cnt_o[i*W +: W], m_cnt[i]);
`ifdef SIFIVE_TRACKER_PEAK_EN
        check($sformatf("peak%0d", i), peak_o[i*W +: W], m_peak[i]);
`endif
      end
      check("idle", idle_o, idl);
      check("err", err_o, m_err);
    end
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_peak[i] = 0;
      end
      m_err = 0;
      known = 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rf[i] && !sf[i]) m_cnt[i]++;
        else if (sf[i] && !rf[i]) begin
          if (m_cnt[i] == 0) m_err = 1;
          else m_cnt[i]--;
        end
        if (m_cnt[i] > m_peak[i])
          m_peak[i] = (m_cnt[i] > MAXO) ? MAXO : m_cnt[i];
      end
    end
  endtask

  initial begin
    // Reset held three cycles, then release
    repeat (3) step(1, '0, '0);
    step(0, '0, '0);

    // Fill channel 0; the 16th request must stall
    repeat (16) step(0, 8'h01, '0);
    #1;
    check("fill_cnt0", cnt_o[0 +: W], 15);
    check("fill_rdy0", req_ready[0], 0);

    // Channel 3 to 15, then request+response at full
    repeat (15) step(0, 8'h08, '0);
    step(0, 8'h08, 8'h08);
    #1;
    check("ch3_after", cnt_o[3*W +: W], 14);
    check("ch3_rdy", req_ready[3], 1);

    // Channel 2 to 4, simultaneous request and response
    repeat (4) step(0, 8'h04, '0);
    step(0, 8'h04, 8'h04);
    #1;
    check("ch2_hold", cnt_o[2*W +: W], 4);

    // Underflow on channel 5 then confirm stickiness
    step(0, '0, 8'h20);
    step(0, '0, '0);
    #1;
    check("unf_err", err_o, 1);
    check("unf_cnt5", cnt_o[5*W +: W], 0);
    step(0, '0, '0);

    // Mid-op reset with ch1=7, ch6=12
    step(1, '0, '0);
    for (int k = 0; k < 12; k++) step(0, (k < 7) ? 8'h42 : 8'h40, '0);
    #1;
    check("pre_rst_ch1", cnt_o[1*W +: W], 7);
    check("pre_rst_ch6", cnt_o[6*W +: W], 12);
    step(1, 8'hff, 8'hff);
    #1;
    check("rst_idle", idle_o, 1);
    check("rst_err", err_o, 0);
    step(0, 8'h02, '0);

`ifdef SIFIVE_TRACKER_PEAK_EN
    // Channel 4 ramps to 9 then drains
    step(1, '0, '0);
    repeat (9) step(0, 8'h10, '0);
    repeat (9) step(0, '0, 8'h10);
    #1;
    check("peak4", peak_o[4*W +: W], 9);
    check("peak4_cnt", cnt_o[4*W +: W], 0);
`endif

    // Random traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] rv, sv;
      rv = N'($urandom);
      if ((k / 300) % 2 == 0) sv = N'($urandom & $urandom & $urandom);
      else sv = N'($urandom | $urandom);
      step(($urandom_range(0, 249) == 0), rv, sv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
